// File: rtl/adder_share_arb.sv
// Round-robin front end that time-shares one combinational adder among NREQ requesters.
// S1 registers the granted operand pair into the adder; S2 captures the sum for the response port.
module adder_share_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 12,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W:0]        add_s,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W:0]        rsp_sum,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_count
);

    logic            s1_v_q, s1_v_d;
    logic [W-1:0]    s1_a_q, s1_a_d;
    logic [W-1:0]    s1_b_q, s1_b_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [W:0]      rsp_sum_q, rsp_sum_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [15:0]     rsp_count_q, rsp_count_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    logic            out_adv, s1_adv, accept_en, accept, any_valid;
    logic [IDW-1:0]  grant;
    logic [W-1:0]    sel_a, sel_b;
    int unsigned     idx;

    assign out_adv   = ~rsp_valid_q | rsp_ready;
    assign s1_adv    = s1_v_q & out_adv;
    assign accept_en = ~s1_v_q | s1_adv;
    assign accept    = accept_en & any_valid & ~rst;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        sel_a     = '0;
        sel_b     = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_valid && req_valid[IDW'(idx)]) begin
                any_valid = 1'b1;
                grant     = IDW'(idx);
                sel_a     = req_a[idx*W +: W];
                sel_b     = req_b[idx*W +: W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready = NREQ'(1) << grant;
        end
    end

    always_comb begin
        s1_v_d      = s1_v_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        rsp_count_d = rsp_count_q;
        ptr_d       = ptr_q;

        if (s1_adv) begin
            s1_v_d      = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_s;
            rsp_id_d    = s1_id_q;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (accept) begin
            s1_v_d  = 1'b1;
            s1_a_d  = sel_a;
            s1_b_d  = sel_b;
            s1_id_d = grant;
            ptr_d   = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
        end

        if (rsp_valid_q && rsp_ready) begin
            rsp_count_d = rsp_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rsp_count_q <= '0;
            ptr_q       <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            rsp_count_q <= rsp_count_d;
            ptr_q       <= ptr_d;
        end
    end

    assign add_a     = s1_a_q;
    assign add_b     = s1_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_count = rsp_count_q;

endmodule
